// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory arbiter.
// Holds the FSM states, the op encoding and the channel limit.
package mem_arb_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_e;

    // A channel index needs at least one bit, even with a single channel.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational grant picker for mem_arbiter.
// MEM_ARB_FIXED_PRIO_EN selects lowest-index-first and drops the pointer.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
`ifndef MEM_ARB_FIXED_PRIO_EN
    input  logic [IDX_W-1:0]  ptr,
`endif
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx
);

    logic found;

    always_comb begin
        int c;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            c = k;
`else
            c = int'(ptr) + k;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
`endif
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: NUM_CH-way front end onto the single shared Mem port.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_rd,
    input  logic [NUM_CH-1:0]        req_wr,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wr_data,
    output logic [NUM_CH-1:0]        req_stall,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_rd_data,
    output logic                     to_mem_rd,
    output logic                     to_mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        to_mem_wr_data,
    input  logic                     from_mem_ready,
    input  logic [DATA_W-1:0]        from_mem_rd_data,
    input  logic                     from_mem_rd_valid
);

    localparam int IDX_W = idx_width(NUM_CH);

    arb_state_e        state_q;
    arb_state_e        state_d;
    arb_op_e           op_q;
    logic [NUM_CH-1:0] gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic [NUM_CH-1:0] req_any;
    logic [NUM_CH-1:0] arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_wr;
    logic              grant_en;

    assign req_any = req_rd | req_wr;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    assign rr_ptr_d = (arb_idx == IDX_W'(NUM_CH - 1)) ? '0
                                                      : arb_idx + 1'b1;
`endif

    rr_arbiter #(
        .NUM_CH(NUM_CH),
        .IDX_W (IDX_W)
    ) u_arb (
`ifndef MEM_ARB_FIXED_PRIO_EN
        .ptr   (rr_ptr_q),
`endif
        .req   (req_any),
        .gnt   (arb_gnt),
        .idx   (arb_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_gnt[i]) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A write wins when a channel raises rd and wr together.
    assign sel_wr = |(arb_gnt & req_wr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_RD;
            gnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                gnt_q    <= arb_gnt;
                op_q     <= sel_wr ? OP_WR : OP_RD;
                addr_q   <= sel_addr;
                wdata_q  <= sel_wdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
                rr_ptr_q <= rr_ptr_d;
`endif
            end
            if (state_q == ST_WAIT_RD && from_mem_rd_valid) begin
                rdata_q <= from_mem_rd_data;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_en  = 1'b0;
        to_mem_rd = 1'b0;
        to_mem_wr = 1'b0;
        rsp_valid = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_any) begin
                    grant_en = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (from_mem_ready) begin
                    to_mem_rd = (op_q == OP_RD);
                    to_mem_wr = (op_q == OP_WR);
                    state_d   = (op_q == OP_WR) ? ST_DONE : ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (from_mem_rd_valid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = gnt_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_stall      = req_any & ~rsp_valid;
    assign rsp_rd_data    = rdata_q;
    assign mem_addr       = addr_q;
    assign to_mem_wr_data = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and a randomized
// run against a transaction-level model of the arbiter and Mem.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        req_rd;
    logic [NUM_CH-1:0]        req_wr;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wr_data;
    logic [NUM_CH-1:0]        req_stall;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]        rsp_rd_data;
    logic                     to_mem_rd;
    logic                     to_mem_wr;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        to_mem_wr_data;
    logic                     from_mem_ready;
    logic [DATA_W-1:0]        from_mem_rd_data = '0;
    logic                     from_mem_rd_valid = 1'b0;

    mem_arbiter #(
        .NUM_CH(NUM_CH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_rd           (req_rd),
        .req_wr           (req_wr),
        .req_addr         (req_addr),
        .req_wr_data      (req_wr_data),
        .req_stall        (req_stall),
        .rsp_valid        (rsp_valid),
        .rsp_rd_data      (rsp_rd_data),
        .to_mem_rd        (to_mem_rd),
        .to_mem_wr        (to_mem_wr),
        .mem_addr         (mem_addr),
        .to_mem_wr_data   (to_mem_wr_data),
        .from_mem_ready   (from_mem_ready),
        .from_mem_rd_data (from_mem_rd_data),
        .from_mem_rd_valid(from_mem_rd_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // Mem model: word-indexed by addr[9:2], read latency mem_lat cycles.
    logic [31:0] mem [0:255];
    bit          mem_inited = 1'b0;
    int          mem_lat = 1;
    int          rd_cnt = 0;
    logic [31:0] rd_buf = '0;

    always @(posedge clk) begin
        from_mem_rd_valid <= 1'b0;
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_inited <= 1'b1;
        end else begin
            if (rd_cnt > 0) begin
                rd_cnt <= rd_cnt - 1;
                if (rd_cnt == 1) begin
                    from_mem_rd_valid <= 1'b1;
                    from_mem_rd_data  <= rd_buf;
                end
            end
            if (from_mem_ready && to_mem_wr)
                mem[mem_addr[9:2]] <= to_mem_wr_data;
            if (from_mem_ready && to_mem_rd) begin
                if (mem_lat <= 1) begin
                    from_mem_rd_valid <= 1'b1;
                    from_mem_rd_data  <= mem[mem_addr[9:2]];
                end else begin
                    rd_cnt <= mem_lat - 1;
                    rd_buf <= mem[mem_addr[9:2]];
                end
            end
        end
    end

    logic [31:0] ref_mem [0:255];

    typedef struct {
        int          ch;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        int          exp_cyc;
        logic        exp_wr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic clear_reqs();
        req_rd      = '0;
        req_wr      = '0;
        req_addr    = '0;
        req_wr_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_reqs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        int   n_rd;
        int   n_wr;
        logic got;
        logic [NUM_CH-1:0] oh;
        cyc  = 1;
        n_rd = 0;
        n_wr = 0;
        got  = 1'b0;
        oh   = '0;
        oh[v.ch] = 1'b1;
        @(negedge clk);
        mem_lat        = v.lat;
        from_mem_ready = 1'b1;
        req_rd[v.ch]   = v.rd;
        req_wr[v.ch]   = v.wr;
        req_addr[v.ch*ADDR_W +: ADDR_W]    = v.addr;
        req_wr_data[v.ch*DATA_W +: DATA_W] = v.data;
        #1;
        check("vec_stall_hi", req_stall[v.ch], 1'b1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            cyc++;
            if (to_mem_rd) begin
                n_rd++;
                check("vec_rd_addr", mem_addr, v.addr);
            end
            if (to_mem_wr) begin
                n_wr++;
                check("vec_wr_addr", mem_addr, v.addr);
                check("vec_wr_data", to_mem_wr_data, v.data);
            end
            if (rsp_valid != '0) begin
                got = 1'b1;
                check("vec_rsp_ch", rsp_valid, oh);
                check("vec_latency", cyc, v.exp_cyc);
                check("vec_stall_rel", req_stall[v.ch], 1'b0);
                if (!v.exp_wr) check("vec_rd_data", rsp_rd_data, v.exp_rd);
                else ref_mem[v.addr[9:2]] = v.data;
                break;
            end
        end
        check("vec_rsp_seen", got, 1'b1);
        check("vec_n_rd", n_rd, v.exp_wr ? 0 : 1);
        check("vec_n_wr", n_wr, v.exp_wr ? 1 : 0);
        clear_reqs();
    endtask

    // Transaction-level model state for the randomized run.
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] m_rd;
    logic [NUM_CH-1:0] m_wr;
    logic [31:0]       m_addr [NUM_CH];
    logic [31:0]       m_data [NUM_CH];
    int                last_gnt;
    int                gch;
    bit                busy;
    bit                issued;
    bit                free_now;

    function automatic int pick(input logic [NUM_CH-1:0] p, input int last);
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int c = 0; c < NUM_CH; c++) if (p[c]) return c;
`else
        for (int k = 1; k <= NUM_CH; k++) begin
            if (p[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        pend     = '0;
        last_gnt = NUM_CH - 1;
        busy     = 1'b0;
        issued   = 1'b0;
        free_now = 1'b1;
        gch      = 0;
    endtask

    task automatic rnd_step(input bit allow_new);
        logic [NUM_CH-1:0] rv;
        logic [NUM_CH-1:0] oh;
        bit done_now;
        int kind;
        done_now = 1'b0;
        @(negedge clk);
        rv = rsp_valid;
        if (rv != '0) begin
            oh = '0;
            if (busy) oh[gch] = 1'b1;
            check("rnd_rsp_ch", rv, oh);
            if (busy) begin
                check("rnd_rsp_issued", issued, 1'b1);
                if (m_wr[gch]) ref_mem[m_addr[gch][9:2]] = m_data[gch];
                else check("rnd_rd_data", rsp_rd_data, ref_mem[m_addr[gch][9:2]]);
                pend[gch] = 1'b0;
            end
            busy     = 1'b0;
            done_now = 1'b1;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!pend[c] && allow_new && $urandom_range(0, 2) == 0) begin
                kind      = $urandom_range(0, 2);
                m_rd[c]   = (kind != 1);
                m_wr[c]   = (kind != 0);
                m_addr[c] = 32'($urandom_range(0, 15)) << 2;
                m_data[c] = $urandom;
                pend[c]   = 1'b1;
            end
            req_rd[c] = pend[c] & m_rd[c];
            req_wr[c] = pend[c] & m_wr[c];
            req_addr[c*ADDR_W +: ADDR_W]    = m_addr[c];
            req_wr_data[c*DATA_W +: DATA_W] = m_data[c];
        end
        from_mem_ready = ($urandom_range(0, 3) != 0);
        mem_lat        = $urandom_range(1, 3);
        #1;
        check("rnd_stall", req_stall, pend & ~rv);
        if (to_mem_rd || to_mem_wr) begin
            check("rnd_cmd_legal",
                  {busy, issued, from_mem_ready, to_mem_rd & to_mem_wr},
                  4'b1010);
            check("rnd_cmd_op", to_mem_wr, m_wr[gch]);
            check("rnd_cmd_addr", mem_addr, m_addr[gch]);
            if (to_mem_wr) check("rnd_cmd_data", to_mem_wr_data, m_data[gch]);
            issued = 1'b1;
        end
        if (free_now && pend != '0) begin
            gch      = pick(pend, last_gnt);
            last_gnt = gch;
            busy     = 1'b1;
            issued   = 1'b0;
            free_now = 1'b0;
        end else if (done_now) begin
            free_now = 1'b1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] order [4];
        int   at [4];
        int   got_n;
        int   n_cmd;
        logic got;
        vec_t v;

        rst            = 1'b0;
        from_mem_ready = 1'b0;
        clear_reqs();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        vecs[0] = '{0, 1'b1, 1'b0, 32'h100, 32'h0, 2, 5, 1'b0, init_val(8'h40)};
        vecs[1] = '{1, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1, 3, 1'b1, 32'h0};
        vecs[2] = '{1, 1'b1, 1'b0, 32'h40, 32'h0, 1, 4, 1'b0, 32'hDEADBEEF};
        vecs[3] = '{0, 1'b1, 1'b1, 32'h8, 32'h5, 1, 3, 1'b1, 32'h0};
        vecs[4] = '{1, 1'b1, 1'b0, 32'h8, 32'h0, 3, 6, 1'b0, 32'h5};
        vecs[5] = '{0, 1'b1, 1'b0, 32'h40, 32'h0, 1, 4, 1'b0, 32'hDEADBEEF};

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, '0);
        check("rst_cmd", {to_mem_rd, to_mem_wr}, 2'b00);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_wr_data", to_mem_wr_data, '0);
        check("rst_rd_data", rsp_rd_data, '0);
        check("rst_stall", req_stall, '0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Contention: both channels request continuously.
        do_reset();
        @(negedge clk);
        from_mem_ready = 1'b1;
        req_wr         = '1;
        req_addr       = {32'h304, 32'h300};
        req_wr_data    = {32'h1111, 32'h0000};
        got_n = 0;
        for (int k = 0; k < 40 && got_n < 4; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                order[got_n] = rsp_valid;
                at[got_n]    = k;
                got_n++;
            end
        end
        check("rr_count", got_n, 4);
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) check("fp_grant", order[i], 2'b01);
        check("fp_ch1_stalled", req_stall[1], 1'b1);
`else
        for (int i = 0; i < 4; i++)
            check("rr_grant", order[i], (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
        for (int i = 1; i < 4; i++) check("rr_spacing", at[i] - at[i-1], 3);
        clear_reqs();

        // Backpressure: ready low for 5 cycles holds the command back.
        @(negedge clk);
        from_mem_ready = 1'b0;
        mem_lat        = 1;
        req_rd[0]      = 1'b1;
        req_addr[31:0] = 32'h20;
        n_cmd = 0;
        repeat (5) begin
            @(negedge clk);
            n_cmd += int'(to_mem_rd) + int'(to_mem_wr);
        end
        check("bp_no_cmd", n_cmd, 0);
        check("bp_stall", req_stall[0], 1'b1);
        from_mem_ready = 1'b1;
        #1;
        check("bp_cmd_on_ready", {to_mem_rd, to_mem_wr}, 2'b10);
        check("bp_cmd_addr", mem_addr, 32'h20);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmd += int'(to_mem_rd) + int'(to_mem_wr);
            if (rsp_valid != '0) begin
                got = 1'b1;
                check("bp_rd_data", rsp_rd_data, init_val(8));
                break;
            end
        end
        check("bp_rsp_seen", got, 1'b1);
        check("bp_cmd_total", n_cmd, 0);
        clear_reqs();

        // Reset while waiting for read data.
        @(negedge clk);
        mem_lat        = 4;
        req_rd[1]      = 1'b1;
        req_addr[63:32] = 32'h44;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (to_mem_rd) got = 1'b1;
        end
        check("rr_mid_cmd_seen", got, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        clear_reqs();
        #1;
        check("mid_rst_rsp", rsp_valid, '0);
        check("mid_rst_cmd", {to_mem_rd, to_mem_wr}, 2'b00);
        check("mid_rst_addr", mem_addr, '0);
        check("mid_rst_rd_data", rsp_rd_data, '0);
        check("mid_rst_stall", req_stall, '0);
        @(negedge clk);
        rst = 1'b1;
        n_cmd = 0;
        got_n = 0;
        repeat (6) begin
            @(negedge clk);
            n_cmd += int'(to_mem_rd) + int'(to_mem_wr);
            if (rsp_valid != '0) got_n++;
        end
        check("mid_rst_no_rsp", got_n, 0);
        check("mid_rst_no_cmd", n_cmd, 0);
        v = '{0, 1'b1, 1'b0, 32'h44, 32'h0, 1, 4, 1'b0, init_val(8'h11)};
        run_vec(v);

        // Randomized traffic against the transaction model.
        do_reset();
        model_reset();
        repeat (500) rnd_step(1'b1);
        for (int k = 0; k < 200 && (pend != '0 || busy); k++) rnd_step(1'b0);
        check("rnd_drained", {busy, pend}, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
